// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read to
// instruction memory, and holds the fetched word until the core consumes it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        stall,
  input  logic        jump,
  input  logic        PCSrc,
  input  logic [31:0] SignImm,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic        rst_done_q, rst_done_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = SignImm << 2;

  always_comb begin
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (PCSrc) begin
      next_pc = pc_plus4 + branch_off;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // NOTE: every always_comb target gets its hold value first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d       = state_q;
    rst_done_d    = rst_done_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      IDLE: begin
        // One settle cycle after reset release before the first request.
        rst_done_d = 1'b1;
        if (rst_done_q) begin
          state_d    = REQ;
          imem_req_d = 1'b1;
        end
      end
      REQ: begin
        if (imem_ready) begin
          imem_req_d = 1'b0;
          if (imem_rvalid) begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = VALID;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          imem_req_d    = 1'b1;
          state_d       = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rst_done_q    <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      pc_q          <= ResetPcAligned;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rst_done_q    <= rst_done_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign Instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed and randomized fetch/consume traffic
// checked against a PC-sequence reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        stall;
  logic        jump;
  logic        PCSrc;
  logic [31:0] SignImm;
  logic [31:0] fetch_count;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          c0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;
  logic [31:0] cur_instr;
  logic [31:0] imm;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .stall       (stall),
    .jump        (jump),
    .PCSrc       (PCSrc),
    .SignImm     (SignImm),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural next-PC rule: jump beats branch, branch adds imm*4 to PC+4.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                           input logic j, input logic b, input logic [31:0] im);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
    if (b) return p4 + im * 32'd4;
    return p4;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  // Memory side: accept after `hold` cycles, respond `lat` cycles after accept.
  task automatic fetch(input logic [31:0] rdata, input int lat, input int hold);
    jump    = 1'($urandom);
    PCSrc   = 1'($urandom);
    SignImm = $urandom;
    wait_req();
    check("imem_addr", imem_addr, exp_pc);
    repeat (hold) begin
      imem_ready = 1'b0;
      @(negedge clk);
      check("req_hold", {31'd0, imem_req}, 32'd1);
    end
    imem_ready = 1'b1;
    if (lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = rdata;
    end
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    if (lat > 0) begin
      check("req_drop", {31'd0, imem_req}, 32'd0);
      repeat (lat - 1) @(negedge clk);
      check("wait_not_valid", {31'd0, instr_valid}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = rdata;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    check("Instr", Instr, rdata);
    check("PC", PC, exp_pc);
    check("PCPlus4", PCPlus4, exp_pc + 32'd4);
    check("fetch_count", fetch_count, exp_count);
    cur_instr = rdata;
  endtask

  // Hold for `stalls` cycles with garbage on every ignored input, then consume.
  task automatic consume(input logic j, input logic b, input logic [31:0] im, input int stalls);
    repeat (stalls) begin
      stall       = 1'b1;
      jump        = 1'($urandom);
      PCSrc       = 1'($urandom);
      SignImm     = $urandom;
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", Instr, cur_instr);
      check("stall_pc", PC, exp_pc);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_count", fetch_count, exp_count);
    end
    imem_rvalid = 1'b0;
    stall       = 1'b0;
    jump        = j;
    PCSrc       = b;
    SignImm     = im;
    @(negedge clk);
    exp_pc    = ref_next(exp_pc, cur_instr, j, b, im);
    exp_count = exp_count + 32'd1;
    check("consumed_valid", {31'd0, instr_valid}, 32'd0);
    check("consumed_req", {31'd0, imem_req}, 32'd1);
    check("consumed_count", fetch_count, exp_count);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall = 1'b0; jump = 1'b0; PCSrc = 1'b0; SignImm = '0;
    exp_pc = 32'd0; exp_count = 32'd0; cur_instr = '0;

    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_pc", PC, 32'd0);
    check("rst_count", fetch_count, 32'd0);

    rst_n = 1'b1;
    @(posedge clk); #1;
    check("req_edge1", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    check("req_edge2", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
    @(negedge clk);

    // Sequential fetch 0, 4, 8 then on to 0x10.
    fetch(32'h2008_0005, 1, 0);
    consume(1'b0, 1'b0, 32'd0, 0);
    c0 = cyc;
    fetch($urandom, 1, 0);
    consume(1'b0, 1'b0, 32'd0, 0);
    check("consume_rate", 32'(cyc - c0), 32'd3);
    fetch($urandom, 1, 0);
    consume(1'b0, 1'b0, 32'd0, 0);
    fetch($urandom, 1, 0);
    consume(1'b0, 1'b0, 32'd0, 0);

    // Branches from 0x10: backward to 0x0C, back to 0x10, forward to 0x20.
    fetch($urandom, 1, 0);
    consume(1'b0, 1'b1, 32'hFFFF_FFFE, 0);
    fetch($urandom, 1, 0);
    consume(1'b0, 1'b0, 32'd0, 0);
    fetch($urandom, 0, 0);
    consume(1'b0, 1'b1, 32'd3, 0);

    // Jump to 0x40, then jump with branch also asserted, behind a 5-cycle stall.
    fetch(32'h0800_0010, 1, 0);
    consume(1'b1, 1'b0, 32'd0, 0);
    fetch(32'h0800_0100, 2, 1);
    consume(1'b1, 1'b1, 32'd5, 5);

    for (int i = 0; i < 40; i++) begin
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 2));
      consume(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
              $urandom, $urandom_range(0, 2));
    end

    // Branch to the top word and check PC+4 wraps to zero.
    fetch($urandom, 1, 0);
    imm = (32'hFFFF_FFFC - exp_pc - 32'd4) >> 2;
    consume(1'b0, 1'b1, imm, 0);
    fetch($urandom, 1, 0);
    check("wrap_pcplus4", PCPlus4, 32'd0);
    consume(1'b0, 1'b0, 32'd0, 0);
    fetch($urandom, 1, 0);
    consume(1'b0, 1'b0, 32'd0, 0);
    fetch($urandom, 1, 0);
    consume(1'b0, 1'b0, 32'd0, 0);

    // Accept the request at 0x8, then reset while waiting for data.
    wait_req();
    check("pre_reset_addr", imem_addr, exp_pc);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_pc", PC, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    check("arst_instr", Instr, 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("stale_valid", {31'd0, instr_valid}, 32'd0);
    check("stale_instr", Instr, 32'd0);
    exp_pc    = 32'd0;
    exp_count = 32'd0;
    fetch(32'h1234_5678, 1, 0);
    consume(1'b0, 1'b0, 32'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream fetch stage for the MIPS core. Holds the program counter and issues word reads to instruction memory over a request/response handshake. Presents the fetched instruction word (Instr) to the control unit and datapath. Computes the next PC from the control outputs: jump, PCSrc, and the sign-extended immediate from the datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] forced to 00 internally.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  read request to instruction memory (registered)
imem_addr  output  32  byte address of request, equals PC; valid while imem_req=1
imem_ready  input  1  memory accepts request in a cycle where imem_req=1
imem_rvalid  input  1  read data valid, one pulse per accepted request
imem_rdata  input  32  instruction word returned
Instr  output  32  current instruction to control unit/datapath
instr_valid  output  1  Instr and PC are valid for execution
PC  output  32  address of Instr
PCPlus4  output  32  PC + 4, modulo 2^32
stall  input  1  downstream hold; instruction not consumed this cycle
jump  input  1  from control unit, valid while instr_valid=1
PCSrc  input  1  from control unit (Branch & Zero_Flag)
SignImm  input  32  sign-extended Instr[15:0] from datapath
fetch_count  output  32  count of instructions consumed, wraps

Behaviour:
- Single clock, asynchronous active-low reset. While rst_n=0:
  - state=IDLE, PC=RESET_PC (low bits 00)
  - imem_req=0, instr_valid=0, Instr=0, fetch_count=0
- Only one outstanding memory request at any time.
- FSM states: IDLE, REQ, WAIT, VALID.
  - IDLE: next cycle -> REQ with imem_req=1. First request appears in the second rising edge after rst_n release.
  - REQ: imem_req=1, imem_addr=PC.
    - imem_ready=1 -> WAIT, imem_req=0 next cycle.
    - imem_ready=1 and imem_rvalid=1 in the same cycle (zero-latency memory): capture imem_rdata -> VALID directly.
  - WAIT: imem_req=0. On imem_rvalid=1: Instr<=imem_rdata, instr_valid<=1 -> VALID.
  - VALID: instr_valid=1; Instr and PC held stable.
    - Consumed in any cycle with stall=0.
    - On consume: PC<=next_pc, instr_valid<=0, fetch_count<=fetch_count+1 -> REQ.
    - stall=1 -> remain in VALID, all outputs unchanged.
- Consumption rate: one instruction per 3 cycles minimum with 1-cycle memory (REQ, WAIT, VALID).
- next_pc rules, evaluated only on consume:
  - jump=1: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - else PCSrc=1: PCPlus4 + {SignImm[29:0], 2'b00}, 32-bit wrapping add.
  - else: PCPlus4.
  - jump has priority over PCSrc when both are 1.
- PCPlus4 is combinational from PC; PC 32'hFFFF_FFFC wraps to 0.
- imem_rvalid outside WAIT (and outside REQ with imem_ready=1) is ignored; no state change.
- imem_rdata is sampled only with imem_rvalid.
- jump, PCSrc and SignImm are ignored when instr_valid=0.
- Reset mid-transaction:
  - State is abandoned immediately; any in-flight response is dropped.
  - Instruction memory shares rst_n and discards pending responses.
- fetch_count wraps 32'hFFFF_FFFF -> 0.

Test Plan:
- Reset release with RESET_PC=0, memory returning data one cycle after accept, imem_rdata=32'h2008_0005 -> imem_req rises 2 edges after release with imem_addr=0; instr_valid=1 with Instr=32'h2008_0005, PC=0.
- Sequential fetch of 3 instructions with stall=0 -> imem_addr sequence 0, 4, 8; fetch_count=3; one consume every 3 cycles.
- Instruction at PC=0x10 with PCSrc=1, SignImm=32'hFFFF_FFFE -> next imem_addr=0x0C. With SignImm=3 -> next imem_addr=0x20.
- Instruction at PC=0x0000_0040 with jump=1, Instr=32'h0800_0100 and PCSrc=1 -> next imem_addr=0x0000_0400 (jump priority).
- stall held 5 cycles in VALID while imem_rvalid is pulsed spuriously -> Instr, PC and instr_valid unchanged; fetch_count unchanged; no new imem_req.
- rst_n asserted in WAIT at PC=0x8, then rvalid arrives after release -> outputs reset asynchronously; stale response ignored in IDLE; first fetch is from RESET_PC.
